// File: rtl/breath_ctrl.sv
// rtl/breath_ctrl.sv - LED breathing sequencer: ramps a PWM duty up, holds, ramps down, holds
//
// Purpose:
//   Walks a duty value through UP -> HOLD_H -> DOWN -> HOLD_L -> UP ... one
//   step per PWM-period tick. The duty output is registered and feeds the PWM
//   compare input directly. Dropping en returns to IDLE with duty forced to 0.
//
// Ports:
//   clk       in   1        sole clock, rising edge
//   rst       in   1        synchronous, active-high reset
//   en        in   1        1 = run the breathing sequence, 0 = force idle
//   tick      in   1        one-cycle strobe per PWM period
//   duty      out  DUTY_W   registered duty value
//   duty_upd  out  1        high in the cycle a new duty value first appears
//   phase     out  3        current state encoding (debug)

module breath_ctrl #(
    parameter int DUTY_W   = 10,
    parameter int DUTY_MAX = 999,
    parameter int STEP     = 4,
    parameter int HOLD_HI  = 250,
    parameter int HOLD_LO  = 250
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              tick,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic [2:0]        phase
);

    // The hold counter only ever reaches HOLD_x-1, so clog2 of the larger
    // hold length is enough; keep at least one bit for the zero/one cases.
    localparam int HOLD_MAX = (HOLD_HI > HOLD_LO) ? HOLD_HI : HOLD_LO;
    localparam int CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    // Terminal count per hold state. A hold length of 0 behaves like 1:
    // the first tick in the hold state leaves it.
    localparam logic [CNT_W-1:0] HI_LAST = CNT_W'((HOLD_HI == 0) ? 0 : HOLD_HI - 1);
    localparam logic [CNT_W-1:0] LO_LAST = CNT_W'((HOLD_LO == 0) ? 0 : HOLD_LO - 1);

    // Comparisons run one bit wider than duty so duty+STEP cannot wrap.
    localparam logic [DUTY_W:0]   DUTY_MAX_X = (DUTY_W+1)'(DUTY_MAX);
    localparam logic [DUTY_W:0]   STEP_X     = (DUTY_W+1)'(STEP);
    localparam logic [DUTY_W-1:0] DUTY_TOP   = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] STEP_D     = DUTY_W'(STEP);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UP     = 3'd1,
        S_HOLD_H = 3'd2,
        S_DOWN   = 3'd3,
        S_HOLD_L = 3'd4
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DUTY_W-1:0] duty_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic              duty_upd_n;
    logic [DUTY_W:0]   duty_x;
    logic [DUTY_W:0]   sum_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            duty     <= '0;
            cnt      <= '0;
            duty_upd <= 1'b0;
        end else begin
            state    <= state_n;
            duty     <= duty_n;
            cnt      <= cnt_n;
            duty_upd <= duty_upd_n;
        end
    end

    always_comb begin
        state_n = state;
        duty_n  = duty;
        cnt_n   = cnt;
        duty_x  = {1'b0, duty};
        sum_x   = duty_x + STEP_X;

        if (!en) begin
            // Disabling wins over a coincident tick: no step is applied.
            state_n = S_IDLE;
            duty_n  = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Start immediately; the first step waits for a tick.
                    state_n = S_UP;
                end
                S_UP: begin
                    if (tick) begin
                        if (sum_x >= DUTY_MAX_X) begin
                            duty_n  = DUTY_TOP;
                            state_n = S_HOLD_H;
                        end else begin
                            duty_n = sum_x[DUTY_W-1:0];
                        end
                    end
                end
                S_HOLD_H: begin
                    if (tick) begin
                        if (cnt == HI_LAST) begin
                            cnt_n   = '0;
                            state_n = S_DOWN;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                end
                S_DOWN: begin
                    if (tick) begin
                        if (duty_x <= STEP_X) begin
                            duty_n  = '0;
                            state_n = S_HOLD_L;
                        end else begin
                            duty_n = duty - STEP_D;
                        end
                    end
                end
                S_HOLD_L: begin
                    if (tick) begin
                        if (cnt == LO_LAST) begin
                            cnt_n   = '0;
                            state_n = S_UP;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    // Encodings 5-7 recover to a clean idle.
                    state_n = S_IDLE;
                    duty_n  = '0;
                    cnt_n   = '0;
                end
            endcase
        end

        // Reset clears the strobe in the register itself, so a reset
        // mid-sequence never pulses it.
        duty_upd_n = (duty_n != duty);
    end

    assign phase = state;

endmodule

// File: doc/breath_ctrl.md
BREATH_CTRL -- requirements
Module: breath_ctrl

Interface
REQ-001 Parameter DUTY_W, default 10, SHALL set the duty output width in bits.
REQ-002 Parameter DUTY_MAX, default 999, SHALL set the saturating top duty value; legal range 1..2^DUTY_W-1.
REQ-003 Parameter STEP, default 4, SHALL set the duty increment/decrement per tick; legal range 1..DUTY_MAX.
REQ-004 Parameter HOLD_HI, default 250, SHALL set the number of ticks spent at DUTY_MAX; 0 is legal.
REQ-005 Parameter HOLD_LO, default 250, SHALL set the number of ticks spent at 0; 0 is legal.
REQ-006 clk  input  1  sole clock; all logic is clocked on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 en  input  1  level; 1 = run the breathing sequence, 0 = force idle.
REQ-009 tick  input  1  single-cycle strobe, one per PWM period (1 ms pulse from the clock divider).
REQ-010 duty  output  DUTY_W  registered duty value; drives the pwm compare input directly.
REQ-011 duty_upd  output  1  single-cycle strobe, high in the cycle a new duty value first appears.
REQ-012 phase  output  3  registered current state encoding, for debug.

Function
REQ-013 FSM states and encodings: IDLE=0, UP=1, HOLD_H=2, DOWN=3, HOLD_L=4; encodings 5-7 are unreachable and SHALL return to IDLE on the next clock.
REQ-014 Priority on every clock: rst first, then en=0, then tick.
REQ-015 en=0 in any non-IDLE state: next cycle state=IDLE, duty=0, hold counter=0; no step is applied even if tick=1 in the same cycle.
REQ-016 IDLE with en=1: move to UP on the next clock without waiting for a tick; duty stays 0.
REQ-017 UP on a tick: if duty+STEP >= DUTY_MAX then duty=DUTY_MAX and state=HOLD_H; otherwise duty=duty+STEP.
REQ-018 DOWN on a tick: if duty <= STEP then duty=0 and state=HOLD_L; otherwise duty=duty-STEP.
REQ-019 HOLD_H/HOLD_L: the hold counter increments once per tick; on the tick where counter==HOLD_x-1, the counter clears and state moves to DOWN or UP respectively; duty is unchanged while holding.
REQ-020 HOLD_x=0: the hold state lasts exactly one tick; that tick only moves state, duty is unchanged, and the next step happens on the following tick.
REQ-021 Duty arithmetic SHALL be done at DUTY_W+1 bits so the compare cannot wrap; duty never exceeds DUTY_MAX and never underflows below 0.
REQ-022 Latency: a tick sampled on edge N produces the new duty and phase after edge N; ticks outside UP/DOWN/HOLD_x are ignored.
REQ-023 duty_upd SHALL equal 1 exactly when duty differs from its value on the previous cycle, including the forced drop to 0 on en=0; it is never asserted for unchanged duty.
REQ-024 Hold counter width SHALL be sized from max(HOLD_HI, HOLD_LO); no tick is lost or double-counted.

Reset
REQ-025 rst=1 SHALL force, on the same edge: state=IDLE, duty=0, duty_upd=0, phase=0, hold counter=0, regardless of en and tick.
REQ-026 Reset release with en=1 SHALL follow REQ-016: UP one clock after rst falls; the first step occurs on the first tick after that.
REQ-027 rst asserted mid-sequence SHALL abandon the sequence with no partial step and no duty_upd pulse.

Verification (DUTY_MAX=999, STEP=4, HOLD_HI=HOLD_LO=2 unless noted)
REQ-028 rst=1 for 2 clocks with en=1 and tick toggling -> duty=0, phase=0, duty_upd=0 throughout.
REQ-029 en=1 then 5 ticks -> duty 4,8,12,16,20, exactly 5 duty_upd pulses, phase=1.
REQ-030 Ramp to 996, then 1 tick -> duty=999, phase=2; 2 ticks -> phase=3, duty=999; next tick -> 995.
REQ-031 DOWN from 999 to 3, then 1 tick -> duty=0, phase=4; 2 ticks -> phase=1; next tick -> 4.
REQ-032 en=0 and tick=1 in the same cycle at duty=400 -> next cycle duty=0, phase=0, duty_upd=1; 396 never appears.
REQ-033 HOLD_HI=0 with rst pulsed during HOLD_H, simultaneous with a tick -> duty=0, phase=0; after release, sequence restarts at 4.
